// File: rtl/byte_packer.sv
// rtl/byte_packer.sv - packs a byte stream into LANES-byte words with flush and lane mask
//
// Purpose:
//   Collects bytes from the byte selector stage into an accumulator and moves
//   each completed (or flushed partial) word into an output register for the
//   word-wide sink.
//
// Ports:
//   clock         rising-edge clock
//   reset         asynchronous active-low reset
//   io_in_valid   byte available
//   io_in_ready   packer accepts a byte this cycle
//   io_in_bits    byte data
//   io_flush      one-cycle request to emit the current partial word
//   io_out_valid  output register holds a word
//   io_out_ready  sink accepts the word this cycle
//   io_out_bits   packed word, unfilled lanes zero
//   io_out_mask   one bit per valid lane
//   io_count      bytes currently in the accumulator
module byte_packer #(
  parameter int LANES         = 4,
  parameter bit LITTLE_ENDIAN = 1'b1
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         io_in_valid,
  output logic                         io_in_ready,
  input  logic [7:0]                   io_in_bits,
  input  logic                         io_flush,
  output logic                         io_out_valid,
  input  logic                         io_out_ready,
  output logic [8*LANES-1:0]           io_out_bits,
  output logic [LANES-1:0]             io_out_mask,
  output logic [$clog2(LANES+1)-1:0]   io_count
);

  localparam int CW = $clog2(LANES + 1);
  localparam int W  = 8 * LANES;
  localparam logic [CW-1:0] LAST = CW'(LANES - 1);
  localparam logic [CW-1:0] FULL = CW'(LANES);

  logic [W-1:0]     acc;
  logic [CW-1:0]    count;
  logic [W-1:0]     obits;
  logic [LANES-1:0] omask;
  logic             ovalid;
  logic             flush_pend;
  // Held low by reset so io_in_ready stays 0 until the first edge after release.
  logic             run;

  logic             slot_free;
  logic             in_fire;
  logic             out_fire;
  logic [CW-1:0]    eff_count;
  logic [W-1:0]     acc_new;
  logic [LANES-1:0] mask_part;
  logic             flush_req;
  logic             word_done;
  logic             partial;
  logic             part_go;
  logic             part_wait;
  logic             load;

  assign slot_free = !ovalid || io_out_ready;
  // count never exceeds LAST, so "count != LAST" means count < LANES-1.
  assign io_in_ready = run && !flush_pend && ((count != LAST) || slot_free);
  assign in_fire   = io_in_valid && io_in_ready;
  assign out_fire  = ovalid && io_out_ready;
  assign eff_count = count + {{(CW-1){1'b0}}, in_fire};

  always_comb begin
    acc_new = acc;
    for (int i = 0; i < LANES; i++) begin
      if (in_fire) begin
        if (LITTLE_ENDIAN) begin
          if (i == int'(count)) acc_new[i*8 +: 8] = io_in_bits;
        end else begin
          if (i == LANES - 1 - int'(count)) acc_new[i*8 +: 8] = io_in_bits;
        end
      end
    end
  end

  always_comb begin
    mask_part = '0;
    for (int i = 0; i < LANES; i++) begin
      if (LITTLE_ENDIAN) mask_part[i] = (i < int'(eff_count));
      else               mask_part[i] = (i >= LANES - int'(eff_count));
    end
  end

  assign flush_req = io_flush || flush_pend;
  assign word_done = in_fire && (count == LAST);
  assign partial   = flush_req && (eff_count != '0) && (eff_count != FULL);
  assign part_go   = partial && slot_free;
  assign part_wait = partial && !slot_free;
  assign load      = word_done || part_go;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      acc        <= '0;
      count      <= '0;
      obits      <= '0;
      omask      <= '0;
      ovalid     <= 1'b0;
      flush_pend <= 1'b0;
      run        <= 1'b0;
    end else begin
      run <= 1'b1;
      // A pending flush is only kept while a partial word waits for the slot;
      // every other flush outcome (empty, completed, moved) clears it.
      flush_pend <= part_wait;
      if (load) begin
        obits  <= acc_new;
        omask  <= word_done ? {LANES{1'b1}} : mask_part;
        ovalid <= 1'b1;
        acc    <= '0;
        count  <= '0;
      end else begin
        if (out_fire) ovalid <= 1'b0;
        acc   <= acc_new;
        count <= eff_count;
      end
    end
  end

  assign io_out_valid = ovalid;
  assign io_out_bits  = obits;
  assign io_out_mask  = omask;
  assign io_count     = count;

endmodule

// File: tb/tb_byte_packer.sv
// tb/tb_byte_packer.sv - directed self-checking bench for byte_packer
module tb_byte_packer;

  logic        clock;
  logic        reset;

  logic        valid, ready, flush, ovalid, oready;
  logic [7:0]  bits;
  logic [31:0] obits;
  logic [3:0]  omask;
  logic [2:0]  count;

  logic        b_valid, b_ready, b_flush, b_ovalid, b_oready;
  logic [7:0]  b_bits;
  logic [31:0] b_obits;
  logic [3:0]  b_omask;
  logic [2:0]  b_count;

  int checks;
  int errors;

  byte_packer #(.LANES(4), .LITTLE_ENDIAN(1'b1)) dut_le (
    .clock(clock), .reset(reset),
    .io_in_valid(valid), .io_in_ready(ready), .io_in_bits(bits),
    .io_flush(flush),
    .io_out_valid(ovalid), .io_out_ready(oready),
    .io_out_bits(obits), .io_out_mask(omask), .io_count(count)
  );

  byte_packer #(.LANES(4), .LITTLE_ENDIAN(1'b0)) dut_be (
    .clock(clock), .reset(reset),
    .io_in_valid(b_valid), .io_in_ready(b_ready), .io_in_bits(b_bits),
    .io_flush(b_flush),
    .io_out_valid(b_ovalid), .io_out_ready(b_oready),
    .io_out_bits(b_obits), .io_out_mask(b_omask), .io_count(b_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clock);
  endtask

  task automatic feed(input logic [7:0] b);
    valid = 1'b1;
    bits  = b;
    step();
    valid = 1'b0;
  endtask

  task automatic feed_b(input logic [7:0] b);
    b_valid = 1'b1;
    b_bits  = b;
    step();
    b_valid = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b0;
    valid = 1'b1; bits = 8'h11; flush = 1'b0; oready = 1'b1;
    b_valid = 1'b0; b_bits = 8'h00; b_flush = 1'b0; b_oready = 1'b1;

    // Reset with valid held high
    #1;
    chk("rst_ovalid", {31'd0, ovalid}, 32'd0);
    chk("rst_obits", obits, 32'd0);
    chk("rst_omask", {28'd0, omask}, 32'd0);
    chk("rst_count", {29'd0, count}, 32'd0);
    chk("rst_ready", {31'd0, ready}, 32'd0);
    step();
    chk("rst_ready_edge", {31'd0, ready}, 32'd0);
    reset = 1'b1;
    step();
    chk("post_rst_ready", {31'd0, ready}, 32'd1);
    chk("post_rst_count", {29'd0, count}, 32'd0);

    // Basic little-endian word
    feed(8'h11); feed(8'h22); feed(8'h33); feed(8'h44);
    chk("le_valid", {31'd0, ovalid}, 32'd1);
    chk("le_bits", obits, 32'h44332211);
    chk("le_mask", {28'd0, omask}, 32'hF);
    chk("le_count", {29'd0, count}, 32'd0);
    step();
    chk("le_valid_1cyc", {31'd0, ovalid}, 32'd0);

    // Backpressure
    oready = 1'b0;
    feed(8'h01); feed(8'h02); feed(8'h03); feed(8'h04);
    chk("bp_w1_valid", {31'd0, ovalid}, 32'd1);
    chk("bp_w1_bits", obits, 32'h04030201);
    feed(8'h05); feed(8'h06); feed(8'h07);
    chk("bp_count3", {29'd0, count}, 32'd3);
    chk("bp_ready_low", {31'd0, ready}, 32'd0);
    chk("bp_w1_stable", obits, 32'h04030201);
    valid = 1'b1; bits = 8'h08;
    step();
    chk("bp_no_accept", {29'd0, count}, 32'd3);
    chk("bp_still_valid", {31'd0, ovalid}, 32'd1);
    chk("bp_still_bits", obits, 32'h04030201);
    oready = 1'b1;
    #1;
    chk("bp_ready_comb", {31'd0, ready}, 32'd1);
    step();
    valid = 1'b0;
    chk("bp_w2_valid", {31'd0, ovalid}, 32'd1);
    chk("bp_w2_bits", obits, 32'h08070605);
    chk("bp_w2_count", {29'd0, count}, 32'd0);
    step();
    chk("bp_drained", {31'd0, ovalid}, 32'd0);

    // Partial flush
    feed(8'hAA); feed(8'hBB);
    chk("pf_count2", {29'd0, count}, 32'd2);
    flush = 1'b1; step(); flush = 1'b0;
    chk("pf_valid", {31'd0, ovalid}, 32'd1);
    chk("pf_bits", obits, 32'h0000BBAA);
    chk("pf_mask", {28'd0, omask}, 32'h3);
    chk("pf_count0", {29'd0, count}, 32'd0);
    step();
    chk("pf_drained", {31'd0, ovalid}, 32'd0);
    flush = 1'b1; step(); flush = 1'b0;
    chk("pf_empty_noword", {31'd0, ovalid}, 32'd0);
    step();
    chk("pf_empty_noword2", {31'd0, ovalid}, 32'd0);

    // Flush coincident with third byte while output is stalled
    oready = 1'b0;
    feed(8'h01); feed(8'h02); feed(8'h03); feed(8'h04);
    feed(8'hAA); feed(8'hBB);
    valid = 1'b1; bits = 8'hCC; flush = 1'b1;
    step();
    valid = 1'b0; flush = 1'b0;
    chk("fp_count3", {29'd0, count}, 32'd3);
    chk("fp_ready_low", {31'd0, ready}, 32'd0);
    valid = 1'b1; bits = 8'hDD; flush = 1'b1;
    step();
    valid = 1'b0; flush = 1'b0;
    chk("fp_no_accept", {29'd0, count}, 32'd3);
    chk("fp_old_bits", obits, 32'h04030201);
    oready = 1'b1;
    #1;
    chk("fp_ready_pend", {31'd0, ready}, 32'd0);
    step();
    chk("fp_valid", {31'd0, ovalid}, 32'd1);
    chk("fp_bits", obits, 32'h00CCBBAA);
    chk("fp_mask", {28'd0, omask}, 32'h7);
    chk("fp_count0", {29'd0, count}, 32'd0);
    step();
    chk("fp_no_second", {31'd0, ovalid}, 32'd0);
    chk("fp_ready_back", {31'd0, ready}, 32'd1);

    // Asynchronous reset mid-word with a stalled valid word
    oready = 1'b0;
    feed(8'h01); feed(8'h02); feed(8'h03); feed(8'h04);
    feed(8'hAA); feed(8'hBB);
    chk("ar_pre_valid", {31'd0, ovalid}, 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("ar_valid_drop", {31'd0, ovalid}, 32'd0);
    chk("ar_count", {29'd0, count}, 32'd0);
    chk("ar_bits", obits, 32'd0);
    chk("ar_ready", {31'd0, ready}, 32'd0);
    step();
    reset = 1'b1; oready = 1'b1;
    step();
    feed(8'h01); feed(8'h02); feed(8'h03); feed(8'h04);
    chk("ar_word_valid", {31'd0, ovalid}, 32'd1);
    chk("ar_word_bits", obits, 32'h04030201);
    chk("ar_word_mask", {28'd0, omask}, 32'hF);
    step();
    chk("ar_word_once", {31'd0, ovalid}, 32'd0);

    // Big-endian instance
    feed_b(8'h11); feed_b(8'h22); feed_b(8'h33); feed_b(8'h44);
    chk("be_valid", {31'd0, b_ovalid}, 32'd1);
    chk("be_bits", b_obits, 32'h11223344);
    chk("be_mask", {28'd0, b_omask}, 32'hF);
    step();
    chk("be_drained", {31'd0, b_ovalid}, 32'd0);
    feed_b(8'h11); feed_b(8'h22);
    b_flush = 1'b1; step(); b_flush = 1'b0;
    chk("be_pf_valid", {31'd0, b_ovalid}, 32'd1);
    chk("be_pf_bits", b_obits, 32'h11220000);
    chk("be_pf_mask", {28'd0, b_omask}, 32'hC);
    chk("be_pf_count", {29'd0, b_count}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/byte_packer.md
Name: byte_packer

Overview:
- Downstream consumer of the byte selector stage: takes the 8-bit selected-byte stream and packs it back into 32-bit words.
- Has a ready/valid handshake on both sides, a flush for partial words, and a byte-lane mask on the output.
- Sits between the byte selector output and the word-wide sink (memory write port / FIFO) in the basic datapath.

Parameters:
- LANES, 4, bytes per output word; output width is 8*LANES; legal values 2..8.
- LITTLE_ENDIAN, 1, when 1 the first byte accepted goes to lane 0 (bits 7:0); when 0 it goes to lane LANES-1.

Ports:
- clock  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low; 0 resets all state immediately.
- io_in_valid  input  1  byte available.
- io_in_ready  output  1  packer can accept a byte this cycle.
- io_in_bits  input  8  byte data (from byte selector io_out).
- io_flush  input  1  one-cycle request to emit the current partial word.
- io_out_valid  output  1  output word register holds a word.
- io_out_ready  input  1  sink accepts the word this cycle.
- io_out_bits  output  8*LANES  packed word; unfilled lanes are 0.
- io_out_mask  output  LANES  1 per valid lane.
- io_count  output  clog2(LANES+1)  bytes currently in the accumulator.

Behaviour:
- Storage:
  - Accumulator: acc, plus count 0..LANES-1.
  - Output register: obits, omask, ovalid.
  - flush_pend flag.
- Reset (reset=0, asynchronous): acc=0, count=0, obits=0, omask=0, ovalid=0, flush_pend=0.
  - Outputs during reset: io_out_valid=0, io_out_bits=0, io_out_mask=0, io_count=0, io_in_ready=0.
  - Release is synchronous to clock. io_in_ready may rise on the first edge after release.
- Handshakes:
  - in_fire = io_in_valid & io_in_ready.
  - out_fire = ovalid & io_out_ready.
  - slot_free = !ovalid | io_out_ready.
- io_in_ready:
  - 1 whenever count < LANES-1 and no flush_pend.
  - When count==LANES-1 (the next byte completes the word), io_in_ready = slot_free & !flush_pend.
  - Combinational from io_out_ready; no path from io_in_valid.
- Accept: on in_fire, the byte is written to lane count (LITTLE_ENDIAN=1) or lane LANES-1-count (LITTLE_ENDIAN=0), and count increments.
- Word complete (in_fire with count==LANES-1):
  - Next cycle: obits = acc with the new byte, omask = all ones, ovalid=1.
  - acc=0, count=0.
  - Latency is 1 cycle from the final byte accept to io_out_valid.
- Drain: on out_fire with no new word loaded, ovalid=0 next cycle. obits and omask hold their last values.
  - Back-to-back works: a new word loads in the same cycle as out_fire.
  - Throughput is 1 byte/cycle sustained with io_out_ready=1.
- Flush request = io_flush | flush_pend. Let eff_count be count plus 1 if in_fire this cycle.
  - eff_count==0: no-op; no empty word is ever emitted; flush_pend cleared.
  - eff_count==LANES: normal word-complete path; flush consumed.
  - 0<eff_count<LANES and slot_free:
    - Next cycle: obits = acc including any byte accepted this cycle, unfilled lanes 0.
    - omask = the eff_count lanes that were filled (low lanes for LITTLE_ENDIAN=1, high lanes for LITTLE_ENDIAN=0).
    - ovalid=1, acc=0, count=0, flush_pend=0.
  - 0<eff_count<LANES and !slot_free: flush_pend=1 and the accept is still performed. While flush_pend=1, io_in_ready=0 until the partial word has been moved.
- io_flush while flush_pend is already 1: absorbed; no second word.
- io_out_bits and io_out_mask are driven from registers; no combinational input-to-output path on data.
- io_out_valid must not drop without out_fire; io_out_bits must stay stable while valid & !ready.
- Reset asserted mid-word or mid-stall: all state cleared; the partial word is discarded.

Test Plan:
- Reset with io_in_valid=1 held: outputs 0 during reset → after release, with LE LANES=4, feed 0x11,0x22,0x33,0x44 on consecutive cycles with io_out_ready=1 → one cycle after the 4th accept, io_out_bits=0x44332211, io_out_mask=0xF, valid for exactly 1 cycle.
- Set LITTLE_ENDIAN=0, same bytes → io_out_bits=0x11223344; a 2-byte flush then gives 0x11220000 with mask=0xC.
- Backpressure: io_out_ready=0, stream 8 bytes 0x01..0x08 → first word 0x04030201 is held stable; io_in_ready=0 when count==3; raise io_out_ready → second word 0x08070605 follows on the next cycle, no byte lost or duplicated.
- Partial flush: feed 0xAA,0xBB then io_flush → io_out_bits=0x0000BBAA, mask=0x3, io_count returns to 0. io_flush with count=0 → no output.
- Flush coincident with the 3rd byte (0xCC) while the output is stalled → flush_pend=1 and io_in_ready=0; after io_out_ready rises, the next word is 0x00CCBBAA with mask=0x7.
- Reset asserted asynchronously mid-clock after 2 bytes and a stalled valid word → io_out_valid drops immediately; after release, feeding 0x01..0x04 yields exactly 0x04030201.
